trace_mem_arbiter: RTL and testbench
====================================

Name: trace_mem_arbiter

Overview:
Shares the single-port trace memory (BRAM) between two requesters: the TraceLogger and the system data interface. Sits between both requesters and the memory macro, replacing their direct memory access. Logger has priority in trace mode, with a starvation guard so the system side still makes progress. In stream mode the two sides alternate strictly, and the current turn is exported.

Parameters:
DATA_W, 32, memory word width (matches TRB_WIDTH)
ADDR_W, 10, memory address width (matches TRB_ADDR_WIDTH)
STARVE_LIMIT, 4, max consecutive logger grants while system request pending (trace mode), range 1..15

Ports:
CLK_I  in  1  system clock
RST_I  in  1  asynchronous reset, active-high
MODE_I  in  1  0 = trace mode, 1 = stream mode; sampled every cycle
LOG_REQ_I  in  1  logger access request; held until granted
LOG_WE_I  in  1  1 = write, 0 = read
LOG_ADDR_I  in  ADDR_W  logger address
LOG_DATA_I  in  DATA_W  logger write data
LOG_GNT_O  out  1  logger request accepted this cycle
LOG_RVALID_O  out  1  LOG_DATA_O valid (one pulse per granted read)
LOG_DATA_O  out  DATA_W  logger read data
SYS_REQ_I, SYS_WE_I, SYS_ADDR_I, SYS_DATA_I, SYS_GNT_O, SYS_RVALID_O, SYS_DATA_O: identical set for the system side
MEM_EN_O  out  1  memory enable (registered)
MEM_WE_O  out  1  memory write enable (registered)
MEM_ADDR_O  out  ADDR_W  memory address (registered)
MEM_DATA_O  out  DATA_W  memory write data (registered)
MEM_DATA_I  in  DATA_W  memory read data; valid 1 cycle after MEM_EN_O && !MEM_WE_O
RW_TURN_O  out  1  0 = logger turn, 1 = system turn

Behaviour:
- Reset (async, RST_I=1): every output except LOG_DATA_O/SYS_DATA_O is 0. This includes MEM_*, *_GNT_O, *_RVALID_O and RW_TURN_O. The starvation counter is 0, the turn is logger and the read-tag pipeline is cleared. LOG_DATA_O/SYS_DATA_O are don't-care while RVALID is 0.
- Grant: combinational from the registered state and the current REQ inputs. At most one GNT_O is high per cycle. Granting means the request is consumed; the requester may change its inputs next cycle.
- Issue: in the grant cycle, the winner's WE/ADDR/DATA are registered onto MEM_* with MEM_EN_O=1. With no grant, MEM_EN_O=0 and the other MEM_* outputs hold their value.
- Read return: a 2-stage tag pipeline {valid, owner} follows each read. RVALID_O of the owner pulses 2 cycles after GNT_O, with *_DATA_O = MEM_DATA_I in that cycle. Writes produce no RVALID. Throughput is 1 access/cycle.
- Trace mode (MODE_I=0):
  - Only LOG_REQ: grant logger. Only SYS_REQ: grant system. Neither: idle.
  - Both requesting: grant logger unless starve_cnt == STARVE_LIMIT, in which case grant system.
  - starve_cnt increments on each logger grant while SYS_REQ_I=1, saturating at STARVE_LIMIT. It clears on any system grant or when SYS_REQ_I=0.
  - RW_TURN_O is registered and equals the owner of the last grant.
- Stream mode (MODE_I=1):
  - Strict alternation. The registered turn toggles every cycle regardless of requests; RW_TURN_O = turn.
  - Only the requester whose turn it is can be granted. A request on the wrong turn waits, so worst-case wait is 1 cycle.
  - starve_cnt is held at 0.
- Mode change mid-operation:
  - Takes effect next cycle.
  - Reads already issued still return to their original owner.
  - On entry to stream mode the turn starts at logger.
- Same-address write then read in consecutive cycles: the read returns the new data (memory is read-after-write by order of issue). The arbiter adds no forwarding.
- Reset asserted mid-read: the pending RVALID is dropped. Requesters must reissue.

Optional Feature:
TRB_ARB_STATS_EN:
- Defined: adds output CONFLICT_CNT_O [15:0] and input CONFLICT_CLR_I.
  - The counter increments, saturating at 16'hFFFF, on every cycle where a REQ is pending and not granted.
  - CONFLICT_CLR_I=1 clears it synchronously; clear wins over increment.
  - Reset value is 0.
- Undefined: neither port exists and no logic is added.

Decomposition:
- DTB_PKG gets the following:
  - arb_owner_t enum (OWNER_LOG=0, OWNER_SYS=1).
  - mem_cmd_t struct {en, we, addr, data}.
  - Constant TRB_ARB_STARVE_LIMIT.
- One sub-module, arb_read_tag_pipe: 2-stage {valid, owner} shift register producing the RVALID routing.

Test Plan:
- Reset mid-traffic: assert RST_I asynchronously between clock edges -> all GNT/RVALID/MEM_EN outputs go to 0 immediately, RW_TURN_O=0.
- Trace mode, single requester: LOG read of addr 0x005, memory holding 0xDEADBEEF -> LOG_GNT_O in cycle 0, MEM_ADDR_O=0x005 in cycle 1, LOG_RVALID_O with LOG_DATA_O=0xDEADBEEF in cycle 2.
- Trace mode, both requesting continuously with STARVE_LIMIT=4 -> grant pattern L,L,L,L,S repeating; no system wait exceeds 4 cycles.
- Stream mode, both requesting continuously -> grants alternate L,S,L,S; RW_TURN_O toggles each cycle. SYS_REQ alone on a logger turn is granted on the next cycle.
- Mode switch 0->1 with 2 reads in flight (one LOG, one SYS) -> each RVALID goes to its original owner with the correct data; the first stream-mode turn is logger.
- Stats (with TRB_ARB_STATS_EN): 10 cycles of both requesting in stream mode -> CONFLICT_CNT_O=10. CONFLICT_CLR_I pulse -> 0.

Source files
------------

// File: rtl/trace_mem_arbiter_pkg.sv
// trace_mem_arbiter_pkg: shared owner/command types and default constants for the trace memory arbiter
// Ports: none (package). Imported by trace_mem_arbiter and arb_read_tag_pipe.
package trace_mem_arbiter_pkg;
    localparam int TRB_WIDTH            = 32;
    localparam int TRB_ADDR_WIDTH       = 10;
    localparam int TRB_ARB_STARVE_LIMIT = 4;
    typedef enum logic {
        OWNER_LOG = 1'b0,
        OWNER_SYS = 1'b1
    } arb_owner_t;
    typedef struct packed {
        logic                      en;
        logic                      we;
        logic [TRB_ADDR_WIDTH-1:0] addr;
        logic [TRB_WIDTH-1:0]      data;
    } mem_cmd_t;
endpackage

// File: rtl/trace_mem_arbiter_tag_pipe.sv
// arb_read_tag_pipe: 2-stage {valid, owner} shift register routing read returns to their requester
// Ports: clk_i/rst_i (async active-high), rd_issue_i/rd_owner_i (read granted this cycle and by whom),
//        log_rvalid_o/sys_rvalid_o (read data on the memory bus belongs to that side this cycle).
module arb_read_tag_pipe
    import trace_mem_arbiter_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rd_issue_i,
    input  arb_owner_t rd_owner_i,
    output logic       log_rvalid_o,
    output logic       sys_rvalid_o
);
    logic [1:0] valid_q;
    arb_owner_t owner0_q, owner1_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q  <= '0;
            owner0_q <= OWNER_LOG;
            owner1_q <= OWNER_LOG;
        end else begin
            valid_q  <= {valid_q[0], rd_issue_i};
            owner0_q <= rd_owner_i;
            owner1_q <= owner0_q;
        end
    end
    assign log_rvalid_o = valid_q[1] && owner1_q == OWNER_LOG;
    assign sys_rvalid_o = valid_q[1] && owner1_q == OWNER_SYS;
endmodule

// File: rtl/trace_mem_arbiter.sv
// trace_mem_arbiter: shares the single-port trace BRAM between the TraceLogger and the system data interface
// Ports: CLK_I, RST_I (async active-high), MODE_I (0 trace / 1 stream),
//        LOG_*/SYS_* request side (REQ/WE/ADDR/DATA in, GNT/RVALID/DATA out),
//        MEM_* registered memory command, MEM_DATA_I read data (1 cycle latency), RW_TURN_O current turn.
// Optional: TRB_ARB_STATS_EN adds CONFLICT_CNT_O[15:0] and CONFLICT_CLR_I.
module trace_mem_arbiter
    import trace_mem_arbiter_pkg::*;
#(
    parameter int DATA_W       = TRB_WIDTH,
    parameter int ADDR_W       = TRB_ADDR_WIDTH,
    parameter int STARVE_LIMIT = TRB_ARB_STARVE_LIMIT
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    input  logic              MODE_I,
    input  logic              LOG_REQ_I,
    input  logic              LOG_WE_I,
    input  logic [ADDR_W-1:0] LOG_ADDR_I,
    input  logic [DATA_W-1:0] LOG_DATA_I,
    output logic              LOG_GNT_O,
    output logic              LOG_RVALID_O,
    output logic [DATA_W-1:0] LOG_DATA_O,
    input  logic              SYS_REQ_I,
    input  logic              SYS_WE_I,
    input  logic [ADDR_W-1:0] SYS_ADDR_I,
    input  logic [DATA_W-1:0] SYS_DATA_I,
    output logic              SYS_GNT_O,
    output logic              SYS_RVALID_O,
    output logic [DATA_W-1:0] SYS_DATA_O,
    output logic              MEM_EN_O,
    output logic              MEM_WE_O,
    output logic [ADDR_W-1:0] MEM_ADDR_O,
    output logic [DATA_W-1:0] MEM_DATA_O,
    input  logic [DATA_W-1:0] MEM_DATA_I,
    output logic              RW_TURN_O
`ifdef TRB_ARB_STATS_EN
    ,
    output logic [15:0]       CONFLICT_CNT_O,
    input  logic              CONFLICT_CLR_I
`endif
);
    // mem_cmd_t is sized by the package widths, so DATA_W/ADDR_W must stay at TRB_WIDTH/TRB_ADDR_WIDTH
    mem_cmd_t   cmd_q, cmd_d;
    arb_owner_t turn_q, turn_d, gnt_owner;
    logic [3:0] starve_q, starve_d;
    logic       mode_q, log_gnt, sys_gnt, gnt, starved;
    assign starved = starve_q == 4'(STARVE_LIMIT);
    // Mode is registered so a change takes effect one cycle later; grants are gated by reset
    // so every grant drops the moment reset is asserted.
    assign sys_gnt = !RST_I && SYS_REQ_I && (mode_q ? turn_q == OWNER_SYS : (!LOG_REQ_I || starved));
    assign log_gnt = !RST_I && LOG_REQ_I && (mode_q ? turn_q == OWNER_LOG : !sys_gnt);
    assign gnt       = log_gnt || sys_gnt;
    assign gnt_owner = sys_gnt ? OWNER_SYS : OWNER_LOG;
    assign cmd_d = sys_gnt ? '{1'b1, SYS_WE_I, SYS_ADDR_I, SYS_DATA_I} :
                   log_gnt ? '{1'b1, LOG_WE_I, LOG_ADDR_I, LOG_DATA_I} :
                             '{1'b0, cmd_q.we, cmd_q.addr, cmd_q.data};
    // Stream entry restarts at logger, stream toggles every cycle, trace follows the last grant.
    assign turn_d = (MODE_I && !mode_q) ? OWNER_LOG :
                    MODE_I              ? (turn_q == OWNER_LOG ? OWNER_SYS : OWNER_LOG) :
                    gnt                 ? gnt_owner : turn_q;
    assign starve_d = (mode_q || !SYS_REQ_I || sys_gnt) ? '0 :
                      (log_gnt && !starved)             ? starve_q + 4'd1 : starve_q;
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            mode_q   <= 1'b0;
            turn_q   <= OWNER_LOG;
            starve_q <= '0;
            cmd_q    <= '0;
        end else begin
            mode_q   <= MODE_I;
            turn_q   <= turn_d;
            starve_q <= starve_d;
            cmd_q    <= cmd_d;
        end
    end
    arb_read_tag_pipe u_tag_pipe (
        .clk_i        (CLK_I),
        .rst_i        (RST_I),
        .rd_issue_i   (gnt && !cmd_d.we),
        .rd_owner_i   (gnt_owner),
        .log_rvalid_o (LOG_RVALID_O),
        .sys_rvalid_o (SYS_RVALID_O)
    );
    assign LOG_GNT_O  = log_gnt;
    assign SYS_GNT_O  = sys_gnt;
    assign LOG_DATA_O = MEM_DATA_I;
    assign SYS_DATA_O = MEM_DATA_I;
    assign MEM_EN_O   = cmd_q.en;
    assign MEM_WE_O   = cmd_q.we;
    assign MEM_ADDR_O = cmd_q.addr;
    assign MEM_DATA_O = cmd_q.data;
    assign RW_TURN_O  = turn_q;
`ifdef TRB_ARB_STATS_EN
    logic [15:0] conflict_q, conflict_d;
    assign conflict_d = CONFLICT_CLR_I ? '0 :
                        (((LOG_REQ_I && !log_gnt) || (SYS_REQ_I && !sys_gnt)) && conflict_q != 16'hFFFF) ?
                        conflict_q + 16'd1 : conflict_q;
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) conflict_q <= '0;
        else conflict_q <= conflict_d;
    end
    assign CONFLICT_CNT_O = conflict_q;
`endif
endmodule

// File: tb/tb_trace_mem_arbiter.sv
// tb_trace_mem_arbiter: directed self-checking bench for trace_mem_arbiter with a behavioural BRAM
module tb_trace_mem_arbiter;
    logic        clk = 1'b0, rst = 1'b1, mode = 1'b0;
    logic        log_req = 1'b0, log_we = 1'b0, sys_req = 1'b0, sys_we = 1'b0;
    logic [9:0]  log_addr = '0, sys_addr = '0;
    logic [31:0] log_wdata = '0, sys_wdata = '0;
    logic        log_gnt, log_rvalid, sys_gnt, sys_rvalid;
    logic [31:0] log_rdata, sys_rdata;
    logic        mem_en, mem_we, rw_turn;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [31:0] mem [0:1023];
`ifdef TRB_ARB_STATS_EN
    logic [15:0] conflict_cnt;
    logic        conflict_clr = 1'b0;
`endif
    int n_checks = 0, n_errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else mem_rdata <= mem[mem_addr];
        end
    end

    trace_mem_arbiter dut (
        .CLK_I        (clk),
        .RST_I        (rst),
        .MODE_I       (mode),
        .LOG_REQ_I    (log_req),
        .LOG_WE_I     (log_we),
        .LOG_ADDR_I   (log_addr),
        .LOG_DATA_I   (log_wdata),
        .LOG_GNT_O    (log_gnt),
        .LOG_RVALID_O (log_rvalid),
        .LOG_DATA_O   (log_rdata),
        .SYS_REQ_I    (sys_req),
        .SYS_WE_I     (sys_we),
        .SYS_ADDR_I   (sys_addr),
        .SYS_DATA_I   (sys_wdata),
        .SYS_GNT_O    (sys_gnt),
        .SYS_RVALID_O (sys_rvalid),
        .SYS_DATA_O   (sys_rdata),
        .MEM_EN_O     (mem_en),
        .MEM_WE_O     (mem_we),
        .MEM_ADDR_O   (mem_addr),
        .MEM_DATA_O   (mem_wdata),
        .MEM_DATA_I   (mem_rdata),
        .RW_TURN_O    (rw_turn)
`ifdef TRB_ARB_STATS_EN
        ,
        .CONFLICT_CNT_O (conflict_cnt),
        .CONFLICT_CLR_I (conflict_clr)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    initial begin
        mem[10'h005] = 32'hDEADBEEF;
        mem[10'h010] = 32'hAAAA0001;
        mem[10'h020] = 32'h55550002;
        #1;
        chk("rst_log_gnt", log_gnt, 0);
        chk("rst_sys_gnt", sys_gnt, 0);
        chk("rst_log_rvalid", log_rvalid, 0);
        chk("rst_sys_rvalid", sys_rvalid, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_rw_turn", rw_turn, 0);
        tick;
        rst = 1'b0;
        tick;
        // single logger read of 0x005
        log_req = 1'b1; log_we = 1'b0; log_addr = 10'h005;
        #1;
        chk("rd_log_gnt", log_gnt, 1);
        chk("rd_sys_gnt", sys_gnt, 0);
        tick;
        log_req = 1'b0;
        #1;
        chk("rd_mem_en", mem_en, 1);
        chk("rd_mem_we", mem_we, 0);
        chk("rd_mem_addr", mem_addr, 10'h005);
        chk("rd_rvalid_early", log_rvalid, 0);
        tick;
        #1;
        chk("rd_log_rvalid", log_rvalid, 1);
        chk("rd_log_data", log_rdata, 32'hDEADBEEF);
        chk("rd_sys_rvalid", sys_rvalid, 0);
        chk("rd_mem_idle", mem_en, 0);
        chk("rd_mem_addr_hold", mem_addr, 10'h005);
        tick;
        #1;
        chk("rd_rvalid_single", log_rvalid, 0);
        // system write then logger read of the same address
        sys_req = 1'b1; sys_we = 1'b1; sys_addr = 10'h007; sys_wdata = 32'h12345678;
        #1;
        chk("wr_sys_gnt", sys_gnt, 1);
        tick;
        sys_req = 1'b0; log_req = 1'b1; log_we = 1'b0; log_addr = 10'h007;
        #1;
        chk("raw_log_gnt", log_gnt, 1);
        chk("wr_mem_we", mem_we, 1);
        chk("wr_mem_addr", mem_addr, 10'h007);
        chk("wr_mem_wdata", mem_wdata, 32'h12345678);
        chk("wr_turn_sys", rw_turn, 1);
        tick;
        log_req = 1'b0;
        #1;
        chk("wr_no_rvalid", sys_rvalid, 0);
        chk("raw_turn_log", rw_turn, 0);
        tick;
        #1;
        chk("raw_rvalid", log_rvalid, 1);
        chk("raw_data", log_rdata, 32'h12345678);
        tick;
        // trace mode contention: L,L,L,L,S repeating
        log_req = 1'b1; log_we = 1'b0; log_addr = 10'h001;
        sys_req = 1'b1; sys_we = 1'b0; sys_addr = 10'h002;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk($sformatf("trace_sys_gnt_%0d", i), sys_gnt, 32'(i % 5 == 4));
            chk($sformatf("trace_log_gnt_%0d", i), log_gnt, 32'(i % 5 != 4));
            tick;
        end
        log_req = 1'b0; sys_req = 1'b0;
        mode = 1'b1;
        tick;
        // stream mode: strict alternation starting at logger
        #1;
        chk("stream_entry_turn", rw_turn, 0);
        log_req = 1'b1; sys_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("stream_log_gnt_%0d", i), log_gnt, 32'(i % 2 == 0));
            chk($sformatf("stream_sys_gnt_%0d", i), sys_gnt, 32'(i % 2 == 1));
            chk($sformatf("stream_turn_%0d", i), rw_turn, 32'(i % 2));
            tick;
        end
        log_req = 1'b0;
        #1;
        chk("stream_sys_wait", sys_gnt, 0);
        chk("stream_wait_turn", rw_turn, 0);
        tick;
        #1;
        chk("stream_sys_next", sys_gnt, 1);
        chk("stream_next_turn", rw_turn, 1);
        sys_req = 1'b0;
        mode = 1'b0;
        tick;
        // mode switch with one logger and one system read in flight
        log_req = 1'b1; log_addr = 10'h010;
        #1;
        chk("sw_log_gnt", log_gnt, 1);
        tick;
        log_req = 1'b0; sys_req = 1'b1; sys_we = 1'b0; sys_addr = 10'h020; mode = 1'b1;
        #1;
        chk("sw_sys_gnt", sys_gnt, 1);
        tick;
        sys_req = 1'b0;
        #1;
        chk("sw_log_rvalid", log_rvalid, 1);
        chk("sw_log_data", log_rdata, 32'hAAAA0001);
        chk("sw_sys_rvalid0", sys_rvalid, 0);
        chk("sw_first_turn", rw_turn, 0);
        tick;
        #1;
        chk("sw_sys_rvalid", sys_rvalid, 1);
        chk("sw_sys_data", sys_rdata, 32'h55550002);
        chk("sw_log_rvalid0", log_rvalid, 0);
        chk("sw_turn_toggle", rw_turn, 1);
        mode = 1'b0;
        tick;
        // async reset with a system read in flight
        sys_req = 1'b1; sys_addr = 10'h020;
        #1;
        chk("ar_sys_gnt", sys_gnt, 1);
        tick;
        #1;
        chk("ar_turn_pre", rw_turn, 1);
        chk("ar_mem_en_pre", mem_en, 1);
        rst = 1'b1;
        #1;
        chk("ar_sys_gnt", sys_gnt, 0);
        chk("ar_log_gnt", log_gnt, 0);
        chk("ar_mem_en", mem_en, 0);
        chk("ar_turn", rw_turn, 0);
        chk("ar_sys_rvalid", sys_rvalid, 0);
        sys_req = 1'b0;
        #1;
        rst = 1'b0;
        tick;
        #1;
        chk("ar_rvalid_dropped", sys_rvalid, 0);
        chk("ar_mem_idle", mem_en, 0);
`ifdef TRB_ARB_STATS_EN
        mode = 1'b1;
        conflict_clr = 1'b1;
        tick;
        conflict_clr = 1'b0;
        #1;
        chk("stats_start", conflict_cnt, 0);
        log_req = 1'b1; sys_req = 1'b1;
        for (int i = 0; i < 10; i++) tick;
        #1;
        chk("stats_cnt10", conflict_cnt, 10);
        conflict_clr = 1'b1;
        tick;
        conflict_clr = 1'b0; log_req = 1'b0; sys_req = 1'b0;
        #1;
        chk("stats_clr", conflict_cnt, 0);
`endif
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
